// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: host-side controller for a single-port synchronous RAM.
// It accepts read and write requests over valid/ready and drives registered
// RAM port signals. It captures the RAM's one-cycle-late read data into a
// valid/ready response, and provides a hardware fill that writes a constant
// value to every RAM location.
module ram_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // host request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // host read response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  // fill control
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              fill_done,
  // RAM port
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR         = 3'd1;
  localparam logic [2:0] S_RD_ISSUE   = 3'd2;
  localparam logic [2:0] S_RD_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP       = 3'd4;
  localparam logic [2:0] S_FILL       = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q,     state_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              fill_done_q, fill_done_d;
  logic [DATA_W-1:0] fill_val_q,  fill_val_d;
  logic [ADDR_W-1:0] fill_cnt_q,  fill_cnt_d;

  // Next-state and next-output logic for the access/fill sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    mem_we_d    = 1'b0;          // write enable is a one-cycle strobe
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    fill_done_d = 1'b0;          // completion is a one-cycle pulse
    fill_val_d  = fill_val_q;
    fill_cnt_d  = fill_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          // Fill wins over a simultaneous request; req_ready is low here.
          fill_val_d = fill_value;
          fill_cnt_d = '0;
          state_d    = S_FILL;
        end else if (req_valid) begin
          mem_addr_d = req_addr;
          if (req_we) begin
            mem_wdata_d = req_wdata;
            mem_we_d    = 1'b1;
            state_d     = S_WR;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      // RAM samples the write on this edge; write enable drops by default.
      S_WR:         state_d = S_IDLE;
      // RAM samples the read address on this edge.
      S_RD_ISSUE:   state_d = S_RD_CAPTURE;
      // RAM output register now holds the addressed word.
      S_RD_CAPTURE: begin
        rsp_rdata_d = mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = fill_cnt_q;
        mem_wdata_d = fill_val_q;
        fill_cnt_d  = fill_cnt_q + 1'b1;   // wraps to zero after the last word
        if (fill_cnt_q == LAST_ADDR) begin
          fill_done_d = 1'b1;
          state_d     = S_WR;              // WR drops mem_we, then back to IDLE
        end
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access or fill at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      fill_done_q <= 1'b0;
      fill_val_q  <= '0;
      fill_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      fill_done_q <= fill_done_d;
      fill_val_q  <= fill_val_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) & ~fill_start;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign fill_done = fill_done_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl. A behavioural RAM sits on the
// memory port, a reference copy of the RAM contents is kept from the
// stimulus, and expected read data is queued at request time and compared
// when the response handshake completes.
module tb_ram_access_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              fill_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q   [$];

  ram_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .busy       (busy),
    .fill_done  (fill_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure accept spacing and read latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM: registered read, write-enable-qualified write.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: compare read data when the response handshake fires.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else                   check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
    end
  end

  // Waits (bounded) for req_ready with req_valid already driven, then steps
  // past the accepting edge; returns the edge count of that edge.
  task automatic wait_accept(output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int acc;
    req_we = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
    wait_accept(acc);
    req_valid = 1'b0;
    ref_mem[a] = d;
    @(negedge clk);
    check("wr_mem_we",    32'(mem_we),    32'd1);
    check("wr_mem_addr",  32'(mem_addr),  32'(a));
    check("wr_mem_wdata", 32'(mem_wdata), 32'(d));
    check("wr_busy",      32'(busy),      32'd1);
    @(negedge clk);
    check("wr_we_drop",   32'(mem_we),    32'd0);
    @(posedge clk);
    #1;
  endtask

  // Read with rsp_ready held low for `hold` cycles once data is presented.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int hold);
    int acc;
    int n = 0;
    logic [DATA_W-1:0] e;
    e = ref_mem[a];
    exp_q.push_back(e);
    req_we = 1'b0; req_addr = a; req_valid = 1'b1; rsp_ready = 1'b0;
    wait_accept(acc);
    req_valid = 1'b0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // rsp_valid becomes visible after the third edge counting the acceptance edge.
    check("rd_latency", 32'(cyc - acc), 32'd2);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid",     32'(rsp_valid), 32'd1);
      check("hold_data",      32'(rsp_rdata), 32'(e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy",      32'(busy),      32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("rsp_req_ready",  32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Full fill; optionally raises a competing write request in the start cycle.
  task automatic do_fill(input logic [DATA_W-1:0] v, input bit with_req);
    int idx = 0;
    int bad = 0;
    int n_done = 0;
    fill_value = v; fill_start = 1'b1;
    if (with_req) begin
      req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h55; req_valid = 1'b1;
    end
    @(negedge clk);
    check("fill_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    fill_start = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < DEPTH + 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        if (mem_addr !== 8'(idx) || mem_wdata !== v) bad++;
        if (fill_done !== (idx == DEPTH - 1)) bad++;
        idx++;
      end else if (idx > 0 && idx < DEPTH) begin
        bad++;   // gap inside the fill burst
      end
      if (fill_done) n_done++;
    end
    check("fill_we_count",   32'(idx),    32'(DEPTH));
    check("fill_errors",     32'(bad),    32'd0);
    check("fill_done_count", 32'(n_done), 32'd1);
    check("fill_busy_end",   32'(busy),   32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = v;
    @(posedge clk);
    #1;
  endtask

  // Fill aborted by reset while address `stop_at` is on the RAM port.
  task automatic do_fill_abort(input logic [DATA_W-1:0] v, input logic [ADDR_W-1:0] stop_at);
    int n = 0;
    int stray = 0;
    fill_value = v; fill_start = 1'b1;
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    @(negedge clk);
    while (!(mem_we && mem_addr == stop_at) && n < DEPTH + 4) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 32'(mem_addr), 32'(stop_at));
    rst_n = 1'b0;
    #1;
    check("abort_mem_we",    32'(mem_we),    32'd0);
    check("abort_mem_addr",  32'(mem_addr),  32'd0);
    check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_fill_done", 32'(fill_done), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
    // Words before stop_at were written; stop_at itself never reached the RAM.
    for (int i = 0; i < int'(stop_at); i++) ref_mem[i] = v;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH + 8; c++) begin
      @(negedge clk);
      if (fill_done || mem_we) stray++;
    end
    check("abort_no_resume", 32'(stray), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int prev;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; fill_start = 1'b0; fill_value = '0;
    #1;
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read of the same word.
    do_write(8'h12, 8'hA5);
    do_read(8'h12, 0);

    // Response held while the host stalls.
    do_read(8'h12, 5);

    // Full fill, then spot reads including both ends.
    do_fill(8'h3C, 1'b0);
    do_read(8'h00, 0);
    do_read(8'h7F, 0);
    do_read(8'hFF, 0);

    // Fill beats a simultaneous write request; the write is never performed.
    do_fill(8'h99, 1'b1);
    do_read(8'h10, 0);

    // Reset in the middle of a fill.
    do_write(8'h80, 8'h77);
    do_fill_abort(8'hE1, 8'h40);
    do_read(8'h80, 0);
    do_read(8'h10, 0);
    do_read(8'h3F, 0);

    // Back-to-back writes with req_valid held high.
    req_we = 1'b1; req_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      req_addr  = 8'(i);
      req_wdata = 8'(i + 1);
      wait_accept(acc);
      ref_mem[i] = 8'(i + 1);
      if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) do_read(8'(i), 0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
